// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX byte feeder: byte width and feeder FSM states.
package uart_pkg;
  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } feed_state_e;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered count/full/empty and a one-cycle overflow pulse.
// Read data is combinational from the head entry; the consumer registers it.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic                     rd_en_i,
  output logic [DATA_W-1:0]        rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [$clog2(DEPTH):0]   count_nxt_o,
  output logic                     overflow_o
);
  import uart_pkg::*;

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d, empty_q, empty_d, ovf_q, ovf_d;
  logic              wr_acc, rd_acc;

  // Acceptance uses the registered flags, so a pop never frees room for a same-cycle write.
  assign wr_acc = wr_en_i & ~full_q;
  assign rd_acc = rd_en_i & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
    ovf_d   = wr_en_i & full_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o   = mem_q[rd_ptr_q];
  assign full_o      = full_q;
  assign empty_o     = empty_q;
  assign count_o     = count_q;
  assign count_nxt_o = count_d;
  assign overflow_o  = ovf_q;
endmodule

// File: rtl/uart_tx_fifo.sv
// Byte buffer feeding the UART transmitter: FIFO plus a feeder FSM that holds
// txd_en_o per frame, waits for the rising edge of txd_flag_i, then idles GAP_CYCLES.
module uart_tx_fifo #(
  parameter int DATA_W     = uart_pkg::UART_DATA_W,
  parameter int DEPTH      = 16,
  parameter int GAP_CYCLES = 2
) (
  input  logic                   sclk,
  input  logic                   rst,
  input  logic                   wr_en_i,
  input  logic [DATA_W-1:0]      wr_data_i,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   overflow_o,
  output logic [DATA_W-1:0]      txd_data_o,
  output logic                   txd_en_o,
  input  logic                   txd_flag_i,
  output logic                   busy_o
);
  import uart_pkg::*;

  localparam int GAP_W = $clog2(GAP_CYCLES) + 1;

  feed_state_e           state_q, state_d;
  logic                  txd_en_q, txd_en_d, busy_q, busy_d, flag_q, done, pop;
  logic [DATA_W-1:0]     txd_data_q, txd_data_d, rd_data;
  logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
  logic [$clog2(DEPTH):0] count_nxt;

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk        (sclk),
    .rst        (rst),
    .wr_en_i    (wr_en_i),
    .wr_data_i  (wr_data_i),
    .rd_en_i    (pop),
    .rd_data_o  (rd_data),
    .full_o     (full_o),
    .empty_o    (empty_o),
    .count_o    (count_o),
    .count_nxt_o(count_nxt),
    .overflow_o (overflow_o)
  );

  // Only a rising edge completes a frame; a flag held high counts once.
  assign done = txd_flag_i & ~flag_q;

  always_comb begin
    state_d    = state_q;
    txd_en_d   = txd_en_q;
    txd_data_d = txd_data_q;
    gap_cnt_d  = gap_cnt_q;
    pop        = 1'b0;
    case (state_q)
      ST_IDLE: if (!empty_o) begin
        pop        = 1'b1;
        txd_data_d = rd_data;
        txd_en_d   = 1'b1;
        state_d    = ST_SEND;
      end
      ST_SEND: if (done) begin
        txd_en_d  = 1'b0;
        gap_cnt_d = '0;
        state_d   = ST_GAP;
      end
      ST_GAP: begin
        gap_cnt_d = gap_cnt_q + GAP_W'(1);
        if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE) | (count_nxt != '0);
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      txd_en_q   <= 1'b0;
      txd_data_q <= '0;
      gap_cnt_q  <= '0;
      flag_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      txd_en_q   <= txd_en_d;
      txd_data_q <= txd_data_d;
      gap_cnt_q  <= gap_cnt_d;
      flag_q     <= txd_flag_i;
      busy_q     <= busy_d;
    end
  end

  assign txd_en_o   = txd_en_q;
  assign txd_data_o = txd_data_q;
  assign busy_o     = busy_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed vector table, hand-written corner sequences and
// random traffic, all checked against a queue-based reference model.
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;
  localparam int GAP   = 2;

  logic       sclk = 1'b0;
  logic       rst = 1'b1, wr_en = 1'b0, flag = 1'b0;
  logic [7:0] wd = 8'h00;
  logic       full_o, empty_o, overflow_o, txd_en_o, busy_o;
  logic [4:0] count_o;
  logic [7:0] txd_data_o;

  int checks = 0;
  int errors = 0;

  uart_tx_fifo #(.DATA_W(8), .DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .sclk(sclk), .rst(rst), .wr_en_i(wr_en), .wr_data_i(wd),
    .full_o(full_o), .empty_o(empty_o), .count_o(count_o), .overflow_o(overflow_o),
    .txd_data_o(txd_data_o), .txd_en_o(txd_en_o), .txd_flag_i(flag), .busy_o(busy_o)
  );

  always #5 sclk = ~sclk;

  // Reference model: a byte queue, the frame currently offered, and a count of
  // edges that must pass after a completion before the next byte may be offered.
  logic [7:0] mq[$];
  logic       m_en = 0, m_ovf = 0, m_busy = 0, m_fprev = 0;
  logic [7:0] m_data = 0;
  int         m_hold = 0;

  task automatic model_edge();
    logic done, full_pre;
    if (rst) begin
      mq.delete();
      m_en = 0; m_data = 0; m_hold = 0; m_fprev = 0; m_ovf = 0; m_busy = 0;
      return;
    end
    done     = flag && !m_fprev;
    m_fprev  = flag;
    full_pre = (mq.size() == DEPTH);
    m_ovf    = wr_en && full_pre;
    if (m_en) begin
      if (done) begin m_en = 0; m_hold = GAP; end
    end else if (m_hold > 0) begin
      m_hold--;
    end else if (mq.size() > 0) begin
      m_data = mq.pop_front();
      m_en   = 1;
    end
    if (wr_en && !full_pre) mq.push_back(wd);
    m_busy = m_en || (m_hold > 0) || (mq.size() > 0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge sclk);
    model_edge();
    #1;
    chk("m_en",    32'(txd_en_o),   32'(m_en));
    chk("m_data",  32'(txd_data_o), 32'(m_data));
    chk("m_count", 32'(count_o),    32'(mq.size()));
    chk("m_empty", 32'(empty_o),    32'(mq.size() == 0));
    chk("m_full",  32'(full_o),     32'(mq.size() == DEPTH));
    chk("m_ovf",   32'(overflow_o), 32'(m_ovf));
    chk("m_busy",  32'(busy_o),     32'(m_busy));
  endtask

  typedef struct {
    logic       rst, wr;
    logic [7:0] d;
    logic       flag;
    logic       en;
    logic [7:0] data;
    int         cnt;
    logic       empty, busy;
  } vec_t;
  vec_t tv[8];

  initial begin
    // Single byte through a full frame: reset, write, pop, flag edge, gap, idle.
    tv[0] = '{1, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0};
    tv[1] = '{0, 1, 8'hCB, 0, 0, 8'h00, 1, 0, 1};
    tv[2] = '{0, 0, 8'h00, 0, 1, 8'hCB, 0, 1, 1};
    tv[3] = '{0, 0, 8'h00, 0, 1, 8'hCB, 0, 1, 1};
    tv[4] = '{0, 0, 8'h00, 1, 0, 8'hCB, 0, 1, 1};
    tv[5] = '{0, 0, 8'h00, 1, 0, 8'hCB, 0, 1, 1};
    tv[6] = '{0, 0, 8'h00, 0, 0, 8'hCB, 0, 1, 0};
    tv[7] = '{0, 0, 8'h00, 0, 0, 8'hCB, 0, 1, 0};
    foreach (tv[i]) begin
      rst = tv[i].rst; wr_en = tv[i].wr; wd = tv[i].d; flag = tv[i].flag;
      step();
      chk($sformatf("tv%0d_en", i),    32'(txd_en_o),   32'(tv[i].en));
      chk($sformatf("tv%0d_data", i),  32'(txd_data_o), 32'(tv[i].data));
      chk($sformatf("tv%0d_count", i), 32'(count_o),    32'(tv[i].cnt));
      chk($sformatf("tv%0d_empty", i), 32'(empty_o),    32'(tv[i].empty));
      chk($sformatf("tv%0d_busy", i),  32'(busy_o),     32'(tv[i].busy));
      chk($sformatf("tv%0d_full", i),  32'(full_o),     32'(0));
    end

    // Stalled transmitter: one byte goes to SEND, the next 16 fill the FIFO.
    wr_en = 1;
    for (int i = 0; i < DEPTH + 1; i++) begin wd = 8'(8'h10 + i); step(); end
    chk("fill_count", 32'(count_o), 32'(DEPTH));
    chk("fill_full",  32'(full_o),  32'(1));
    wd = 8'hEE; step();
    chk("ovf_pulse", 32'(overflow_o), 32'(1));
    chk("ovf_count", 32'(count_o),    32'(DEPTH));
    wr_en = 0; step();
    chk("ovf_clear", 32'(overflow_o), 32'(0));

    // Complete the frame, then write on the very cycle the FSM pops from a full FIFO.
    flag = 1; step();
    flag = 0; step(); step();
    wr_en = 1; wd = 8'hAA; step();
    chk("popfull_ovf",   32'(overflow_o), 32'(1));
    chk("popfull_count", 32'(count_o),    32'(DEPTH - 1));
    chk("popfull_en",    32'(txd_en_o),   32'(1));
    wr_en = 0;

    // Flag held high: exactly one completion, next byte waits in SEND.
    flag = 1;
    for (int i = 0; i < 50; i++) step();
    chk("hold_count", 32'(count_o),  32'(DEPTH - 2));
    chk("hold_en",    32'(txd_en_o), 32'(1));
    flag = 0; step();

    // Drain with flag pulses; stored bytes must come out in order (model-checked).
    for (int i = 0; i < 600 && (busy_o || !empty_o); i++) begin
      flag = txd_en_o; step();
      flag = 0; step();
    end
    chk("drain_busy", 32'(busy_o), 32'(0));

    // Reset in the middle of a frame with 5 queued.
    wr_en = 1;
    for (int i = 0; i < 6; i++) begin wd = 8'(8'h50 + i); step(); end
    wr_en = 0; step();
    chk("pre_rst_count", 32'(count_o), 32'(5));
    rst = 1; step();
    chk("rst_en",    32'(txd_en_o), 32'(0));
    chk("rst_count", 32'(count_o),  32'(0));
    chk("rst_empty", 32'(empty_o),  32'(1));
    rst = 0; flag = 1; step();
    flag = 0; step(); step();
    chk("post_rst_en",   32'(txd_en_o), 32'(0));
    chk("post_rst_busy", 32'(busy_o),   32'(0));

    // Random traffic with an erratic transmitter and rare resets.
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(499) == 0);
      wr_en = ($urandom_range(2) == 0);
      wd    = 8'($urandom);
      flag  = ($urandom_range(5) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
